// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and UART_CON bit positions.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // UART_CON bit positions, shared with the transmitter and the register file.
    localparam int UART_CON_RX_EN_BIT    = 1;
    localparam int UART_CON_RX_VALID_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// Register-file side of the UART receiver: control strobes in, data and status out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_core_if;
    import uart_pkg::*;

    logic                 rx_en;
    logic                 rx_ack;
    logic                 err_clr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (
        output rx_en, rx_ack, err_clr,
        input  rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err
    );

    modport slave (
        input  rx_en, rx_ack, err_clr,
        output rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err
    );
`else
    modport master (
        output rx_en, rx_ack, err_clr,
        input  rx_data, rx_valid, rx_busy, frame_err, overrun
    );

    modport slave (
        input  rx_en, rx_ack, err_clr,
        output rx_data, rx_valid, rx_busy, frame_err, overrun
    );
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high line
// never looks like a start bit while coming out of reset.
module uart_rx_sync (
    input  logic sysclk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    // NOTE: sequential state is written with <= only, so every flop sees pre-edge values.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling, sticky valid and framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit check and the parity_err flag.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 64
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          RX,
    uart_rx_core_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 cnt_half, cnt_last;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_q, parity_err_d;
`endif

    uart_rx_sync u_sync (
        .sysclk  (sysclk),
        .reset   (reset),
        .async_i (RX),
        .sync_o  (rx_s)
    );

    assign cnt_half = (cnt_q == CNT_HALF);
    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_inc  = cnt_q + CNT_ONE;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!rx_s) state_d = ST_START;
            ST_START:  if (cnt_half) state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:   if (cnt_last && idx_q == IDX_LAST) state_d = ST_PARITY;
            ST_PARITY: if (cnt_last) state_d = ST_STOP;
`else
            ST_DATA:   if (cnt_last && idx_q == IDX_LAST) state_d = ST_STOP;
`endif
            ST_STOP:   if (cnt_last) state_d = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Disabling the receiver aborts whatever frame is in flight.
        if (!bus.rx_en) state_d = ST_IDLE;
    end

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        cnt_d        = '0;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q & ~bus.rx_ack;
        frame_err_d  = frame_err_q & ~bus.err_clr;
        overrun_d    = overrun_q & ~bus.err_clr;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q & ~bus.err_clr;
`endif
        if (bus.rx_en) begin
            unique case (state_q)
                ST_START: begin
                    cnt_d = cnt_half ? '0 : cnt_inc;
                    idx_d = '0;
                end
                ST_DATA: begin
                    cnt_d = cnt_last ? '0 : cnt_inc;
                    if (cnt_last) begin
                        shreg_d[idx_q] = rx_s;
                        idx_d          = idx_q + IDX_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    cnt_d = cnt_last ? '0 : cnt_inc;
                    if (cnt_last && (rx_s != ^shreg_q)) parity_err_d = 1'b1;
                end
`endif
                ST_STOP: begin
                    cnt_d = cnt_last ? '0 : cnt_inc;
                    if (cnt_last) begin
                        if (rx_s) begin
                            // A completion beats a same-cycle ack: valid stays set, no overrun.
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            if (rx_valid_q && !bus.rx_ack) overrun_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_busy   = (state_q != ST_IDLE);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial UART receiver for the peripheral subsystem.
- Converts 8N1 frames on the RX pin into bytes for the peripheral register file.
- The register file handles bus decode at 0x4000001C and UART_CON; this block does not.
- Samples RX mid-bit using a cycle counter on sysclk, flags framing/overrun errors, and raises a sticky data-valid that the bus read clears.

Parameters:
- CLKS_PER_BIT, 64, sysclk cycles per bit period; even, >= 8.
- DATA_BITS, 8, payload bits per frame, LSB first; fixed at 8 in this revision.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_en  in  1  receive enable (UART_CON[1]).
- RX  in  1  asynchronous serial line, idle high.
- rx_ack  in  1  one-cycle strobe: bus read of the RX data register.
- err_clr  in  1  one-cycle strobe: clears error flags.
- rx_data  out  8  last good received byte.
- rx_valid  out  1  sticky; new byte available (UART_CON[3] / irq source).
- rx_busy  out  1  high while FSM not IDLE.
- frame_err  out  1  sticky; stop bit sampled low.
- overrun  out  1  sticky; byte completed while rx_valid already high.

Behaviour:
- Reset (reset==0 at sysclk edge):
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - FSM=IDLE, counters=0, synchronizer flops=1.
  - Reset mid-frame discards the partial byte.
- Input sync: RX passes through 2 flops (reset value 1) giving rx_s; 2-cycle latency.
- Bit counter cnt: width clog2(CLKS_PER_BIT); bit index: 3 bits.
- IDLE:
  - rx_busy=0.
  - If rx_en && rx_s==0: go START, cnt=0.
- START:
  - cnt increments.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - If 1 (glitch): go IDLE, no flags.
  - If 0: cnt=0, idx=0, go DATA.
- DATA:
  - At cnt==CLKS_PER_BIT-1: shift rx_s into shreg[idx] (LSB first), cnt=0, idx++.
  - After idx==7 sampled: go STOP (or PARITY when enabled).
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1:
    - rx_data<=shreg, rx_valid<=1.
    - If rx_valid was already 1 and rx_ack not asserted this cycle, overrun<=1.
    - Go IDLE.
  - If 0: frame_err<=1, rx_data unchanged, go BREAK.
- BREAK: wait for rx_s==1, then go IDLE. Prevents a held-low line from retriggering.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 sysclk edges after the first edge where RX is low (611 at default).
- rx_ack:
  - Clears rx_valid next edge.
  - Same cycle as a byte completion: the completion wins, rx_valid stays 1, no overrun.
- err_clr clears frame_err and overrun. A set event in the same cycle wins.
- rx_en=0:
  - Forces FSM to IDLE next edge, aborting any frame.
  - rx_valid, rx_data and error flags hold.
- rx_busy=1 in every state except IDLE.
- Back-to-back frames: a start bit immediately after the stop sample is accepted. The FSM is IDLE one cycle after STOP.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - State PARITY follows DATA, sampling one extra bit at CLKS_PER_BIT.
  - Even parity is checked against shreg.
  - Output parity_err (1 bit, sticky, cleared by err_clr, reset 0) is added.
  - A parity-failing byte is still loaded into rx_data and sets rx_valid.
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - DATA_BITS constant.
  - UART_CON bit-position constants, shared with the transmitter and register file.
- Sub-module uart_rx_sync: 2-flop synchronizer with reset-to-1. Reused by other async peripheral inputs (switch).

Test Plan:
- Default params, rx_en=1, send frame 0x05 (start, 1,0,1,0,0,0,0,0, stop) at 64 clks/bit -> rx_valid rises at edge 611, rx_data=0x05, frame_err=0, rx_busy falls with it.
- RX low for 20 cycles then high -> START rejects at mid-bit; rx_valid, frame_err stay 0; FSM back in IDLE by cycle ~35.
- Send 0x0A with stop bit 0, line returns high 64 cycles later -> frame_err=1, rx_data unchanged, rx_valid 0; err_clr pulse -> frame_err=0.
- Send 0x0F then 0x14 without rx_ack -> rx_data=0x14, rx_valid=1, overrun=1. Repeat with rx_ack pulsed on the exact completion edge of 0x14 -> overrun=0, rx_valid=1.
- Assert reset at bit 4 of a frame, release, send 0x19 -> all outputs 0 during reset, then clean receive of 0x19. Separately, drop rx_en mid-frame -> immediate IDLE, no rx_valid.
- (UART_RX_PARITY_EN) send 0x03 with parity bit 1 -> rx_valid=1, parity_err=1; with parity bit 0 -> parity_err=0.
